memory_access_stage: RTL and testbench



---
 rtl/memory_access_stage.sv | 144 ++++++++++++++
 tb/tb_memory_access_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM stage: data memory, load/store lanes, branch resolve, misalignment fault capture
//
// Ports:
//   Clock, Reset           rising-edge clock, synchronous active-high reset
//   RegWriteIn/Out         register write enable (forced low on misaligned load or reset)
//   MemToRegIn/Out         writeback select, pass-through
//   MemReadIn, MemWriteIn  load / store enables
//   BranchIn, Zero_In      branch qualifier and ALU zero flag -> PCSrc_Out
//   MemSize_In             00 word, 01 half, 10 byte, 11 word
//   MemSigned_In           sign-extend sub-word loads when 1
//   ALUResult_In/Out       effective address, passed through
//   W_Data_In              store data (sub-word stores use low bits)
//   R_Data_Out             extended load data, 0 when not an aligned load
//   rDestSelected_in/Out   destination register, pass-through
//   PCNew_in/Out           branch target, pass-through
//   Misaligned_Out         current access is misaligned
//   Fault_Out              sticky misalignment flag
//   FaultAddr_Out          address of the first misaligned access
module memory_access_stage #(
  parameter int ADDR_W   = 10,
  parameter     MEM_INIT = ""
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RegWriteIn,
  input  logic        MemToRegIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        BranchIn,
  input  logic        Zero_In,
  input  logic [1:0]  MemSize_In,
  input  logic        MemSigned_In,
  input  logic [31:0] ALUResult_In,
  input  logic [31:0] W_Data_In,
  input  logic [4:0]  rDestSelected_in,
  input  logic [31:0] PCNew_in,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic        PCSrc_Out,
  output logic [31:0] R_Data_Out,
  output logic [31:0] ALUResult_Out,
  output logic [4:0]  rDestSelected_Out,
  output logic [31:0] PCNew_Out,
  output logic        Misaligned_Out,
  output logic        Fault_Out,
  output logic [31:0] FaultAddr_Out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [0:DEPTH-1];

  // Memory starts at zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
  end

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              is_half;
  logic              is_byte;
  logic              is_word;
  logic [31:0]       rword;
  logic [15:0]       lane_h;
  logic [7:0]        lane_b;
  logic [31:0]       wmask;
  logic [31:0]       wdata;
  logic [31:0]       merged;
  logic              store_en;

  // Upper address bits are dropped, so accesses wrap around the memory.
  assign idx     = ALUResult_In[ADDR_W+1:2];
  assign lane    = ALUResult_In[1:0];
  assign is_half = (MemSize_In == 2'b01);
  assign is_byte = (MemSize_In == 2'b10);
  assign is_word = !is_half && !is_byte;

  assign Misaligned_Out = (MemReadIn || MemWriteIn) &&
                          ((is_half && lane[0]) || (is_word && (lane != 2'b00)));

  // Asynchronous read gives read-before-write behaviour for a same-cycle store.
  assign rword = mem[idx];

  always_comb begin
    lane_b = 8'h00;
    case (lane)
      2'd0:    lane_b = rword[7:0];
      2'd1:    lane_b = rword[15:8];
      2'd2:    lane_b = rword[23:16];
      default: lane_b = rword[31:24];
    endcase
    lane_h = lane[1] ? rword[31:16] : rword[15:0];

    R_Data_Out = 32'h0;
    if (MemReadIn && !Misaligned_Out) begin
      if (is_half)
        R_Data_Out = {{16{MemSigned_In & lane_h[15]}}, lane_h};
      else if (is_byte)
        R_Data_Out = {{24{MemSigned_In & lane_b[7]}}, lane_b};
      else
        R_Data_Out = rword;
    end
  end

  // Replicating the sub-word data across the word lets the lane mask alone
  // pick which bytes land.
  always_comb begin
    wmask = 32'hFFFF_FFFF;
    wdata = W_Data_In;
    if (is_half) begin
      wmask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      wdata = {2{W_Data_In[15:0]}};
    end else if (is_byte) begin
      wmask = 32'h0000_00FF << {lane, 3'b000};
      wdata = {4{W_Data_In[7:0]}};
    end
    merged = (rword & ~wmask) | (wdata & wmask);
  end

  assign store_en = MemWriteIn && !Misaligned_Out && !Reset;

  always_ff @(posedge Clock) begin
    if (store_en) mem[idx] <= merged;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Fault_Out     <= 1'b0;
      FaultAddr_Out <= 32'h0;
    end else if (Misaligned_Out && !Fault_Out) begin
      Fault_Out     <= 1'b1;
      FaultAddr_Out <= ALUResult_In;
    end
  end

  // A misaligned load must not write garbage into the register file.
  assign RegWriteOut       = RegWriteIn && !Reset && !(Misaligned_Out && MemReadIn);
  assign PCSrc_Out         = BranchIn && Zero_In && !Reset;
  assign MemToRegOut       = MemToRegIn;
  assign ALUResult_Out     = ALUResult_In;
  assign rDestSelected_Out = rDestSelected_in;
  assign PCNew_Out         = PCNew_in;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - directed self-checking bench for memory_access_stage
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_in, mem_to_reg_in, mem_read, mem_write, branch, zero;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [31:0] alu_in, wdata_in, pc_in;
  logic [4:0]  rdest_in;
  logic        reg_write_out, mem_to_reg_out, pcsrc, misaligned, fault;
  logic [31:0] rdata, alu_out, pc_out, fault_addr;
  logic [4:0]  rdest_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.ADDR_W(10), .MEM_INIT("")) dut (
    .Clock(clk), .Reset(rst),
    .RegWriteIn(reg_write_in), .MemToRegIn(mem_to_reg_in),
    .MemReadIn(mem_read), .MemWriteIn(mem_write),
    .BranchIn(branch), .Zero_In(zero),
    .MemSize_In(mem_size), .MemSigned_In(mem_signed),
    .ALUResult_In(alu_in), .W_Data_In(wdata_in),
    .rDestSelected_in(rdest_in), .PCNew_in(pc_in),
    .RegWriteOut(reg_write_out), .MemToRegOut(mem_to_reg_out),
    .PCSrc_Out(pcsrc), .R_Data_Out(rdata),
    .ALUResult_Out(alu_out), .rDestSelected_Out(rdest_out),
    .PCNew_Out(pc_out), .Misaligned_Out(misaligned),
    .Fault_Out(fault), .FaultAddr_Out(fault_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one access at the falling edge, then let combinational outputs settle.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_size = sz; mem_signed = sgn;
    alu_in = addr; wdata_in = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; reg_write_in = 1'b1; mem_to_reg_in = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; branch = 1'b1; zero = 1'b1;
    mem_size = 2'b00; mem_signed = 1'b0; alu_in = 32'h0; wdata_in = 32'h0;
    rdest_in = 5'd0; pc_in = 32'h0;

    // Reset state
    tick();
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    chk("rst_regwrite", {31'b0, reg_write_out}, 32'd0);
    chk("rst_pcsrc", {31'b0, pcsrc}, 32'd0);
    @(negedge clk);
    rst = 1'b0; branch = 1'b0; zero = 1'b0;

    // Word store then load
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF); tick();
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("word_load", rdata, 32'hDEADBEEF);
    chk("word_load_regwrite", {31'b0, reg_write_out}, 32'd1);
    chk("word_load_aligned", {31'b0, misaligned}, 32'd0);

    // Byte lanes
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h11223344); tick();
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h000000AA); tick();
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    chk("byte_store_merge", rdata, 32'h11AA3344);
    access(1'b1, 1'b0, 2'b10, 1'b1, 32'h22, 32'h0);
    chk("byte_load_signed", rdata, 32'hFFFFFFAA);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
    chk("byte_load_unsigned", rdata, 32'h000000AA);

    // Half access
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    chk("half_load_hi_signed", rdata, 32'h000011AA);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h20, 32'h12348001); tick();
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    chk("half_load_lo_signed", rdata, 32'hFFFF8001);
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    chk("half_store_merge", rdata, 32'h11AA8001);

    // Misalignment and fault capture
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h55555555);
    chk("mis_word_flag", {31'b0, misaligned}, 32'd1);
    chk("mis_fault_before_edge", {31'b0, fault}, 32'd0);
    tick();
    chk("mis_fault_set", {31'b0, fault}, 32'd1);
    chk("mis_fault_addr", fault_addr, 32'h13);
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("mis_store_suppressed", rdata, 32'hDEADBEEF);
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h21, 32'h0);
    chk("mis_half_rdata", rdata, 32'h0);
    chk("mis_half_regwrite", {31'b0, reg_write_out}, 32'd0);
    chk("mis_half_flag", {31'b0, misaligned}, 32'd1);
    tick();
    chk("fault_addr_sticky", fault_addr, 32'h13);

    // Read-before-write in the same cycle
    access(1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'hCAFEF00D);
    chk("rbw_old_data", rdata, 32'hDEADBEEF);
    tick();
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("rbw_new_data", rdata, 32'hCAFEF00D);

    // Reset blocks stores, clears faults, gates PCSrc
    @(negedge clk);
    rst = 1'b1; branch = 1'b1; zero = 1'b1;
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h12345678);
    chk("rst_pcsrc_gated", {31'b0, pcsrc}, 32'd0);
    tick();
    chk("rst_clears_fault", {31'b0, fault}, 32'd0);
    chk("rst_clears_fault_addr", fault_addr, 32'h0);
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    tick();
    chk("rst_beats_mis_fault", {31'b0, fault}, 32'd0);
    @(negedge clk);
    rst = 1'b0; branch = 1'b0; zero = 1'b0;
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("rst_store_dropped", rdata, 32'hCAFEF00D);

    // Address wrap
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h1010, 32'h0BADC0DE); tick();
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("addr_wrap", rdata, 32'h0BADC0DE);

    // Byte at lane 3 is never misaligned
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h00000077);
    chk("byte_lane3_aligned", {31'b0, misaligned}, 32'd0);
    tick();
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("byte_lane3_merge", rdata, 32'h77ADC0DE);

    // Branch resolution and pass-throughs
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    branch = 1'b1; zero = 1'b1; pc_in = 32'h0000_0400;
    alu_in = 32'hA5A5_0001; rdest_in = 5'd17; mem_to_reg_in = 1'b1;
    #1;
    chk("branch_taken", {31'b0, pcsrc}, 32'd1);
    chk("pcnew_pass", pc_out, 32'h0000_0400);
    chk("alu_pass", alu_out, 32'hA5A5_0001);
    chk("rdest_pass", {27'b0, rdest_out}, 32'd17);
    chk("memtoreg_pass", {31'b0, mem_to_reg_out}, 32'd1);
    chk("no_access_rdata", rdata, 32'h0);
    zero = 1'b0;
    #1;
    chk("branch_not_taken", {31'b0, pcsrc}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
